logic_unit_pipe: RTL and testbench



---
 rtl/logic_unit_pipe.sv | 172 +++++++++++++++++
 tb/tb_logic_unit_pipe.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit.
// Stage 1 captures operands on the input handshake; stage 2 computes the
// selected operation, registers the result with its flags, and presents it
// to the consumer. Optional accumulate mode substitutes the last result for
// operand B.
module logic_unit_pipe #(
  parameter int unsigned           WIDTH    = 4,
  parameter logic [WIDTH-1:0]      ACC_INIT = '0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP,
  input  logic             ACC,
  input  logic             ACC_CLR,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] OUT,
  output logic             ZERO,
  output logic             ONES,
  output logic             PARITY,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  typedef enum logic [2:0] {
    OP_PASS_A = 3'd0,
    OP_NOT_A  = 3'd1,
    OP_AND    = 3'd2,
    OP_OR     = 3'd3,
    OP_XOR    = 3'd4,
    OP_NAND   = 3'd5,
    OP_NOR    = 3'd6,
    OP_XNOR   = 3'd7
  } op_e;

  // Stage 1 registers
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q,     s1_a_d;
  logic [WIDTH-1:0] s1_b_q,     s1_b_d;
  op_e              s1_op_q,    s1_op_d;
  logic             s1_acc_q,   s1_acc_d;

  // Stage 2 registers
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] out_q,      out_d;
  logic             zero_q,     zero_d;
  logic             ones_q,     ones_d;
  logic             parity_q,   parity_d;

  // Accumulator
  logic [WIDTH-1:0] acc_q,      acc_d;

  // Handshake / datapath intermediates
  logic             s2_free;
  logic             s1_move;
  logic             in_fire;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] result;

  // Pipeline advance conditions
  always_comb begin
    s2_free  = !s2_valid_q || OUT_READY;
    s1_move  = s1_valid_q && s2_free;
    IN_READY = !s1_valid_q || s1_move;
    in_fire  = IN_VALID && IN_READY;
  end

  // Stage-2 compute: operand B comes from the accumulator in accumulate mode
  always_comb begin
    opb    = s1_acc_q ? acc_q : s1_b_q;
    result = '0;
    unique case (s1_op_q)
      OP_PASS_A: result = s1_a_q;
      OP_NOT_A:  result = ~s1_a_q;
      OP_AND:    result = s1_a_q & opb;
      OP_OR:     result = s1_a_q | opb;
      OP_XOR:    result = s1_a_q ^ opb;
      OP_NAND:   result = ~(s1_a_q & opb);
      OP_NOR:    result = ~(s1_a_q | opb);
      OP_XNOR:   result = ~(s1_a_q ^ opb);
      default:   result = '0;
    endcase
  end

  // Stage 1 next state: capture on handshake, drain when handed to stage 2
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_acc_d   = s1_acc_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_a_d     = A;
      s1_b_d     = B;
      s1_op_d    = op_e'(OP);
      s1_acc_d   = ACC;
    end else if (s1_move) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2 next state: load result and flags, or drop valid once consumed
  always_comb begin
    s2_valid_d = s2_valid_q;
    out_d      = out_q;
    zero_d     = zero_q;
    ones_d     = ones_q;
    parity_d   = parity_q;
    if (s1_move) begin
      s2_valid_d = 1'b1;
      out_d      = result;
      zero_d     = ~|result;
      ones_d     = &result;
      parity_d   = ^result;
    end else if (OUT_READY) begin
      s2_valid_d = 1'b0;
    end
  end

  // Accumulator next state: clear takes priority over the stage-2 load, but
  // the result loaded into OUT on that edge still used the pre-clear value
  always_comb begin
    acc_d = acc_q;
    if (ACC_CLR) begin
      acc_d = ACC_INIT;
    end else if (s1_move) begin
      acc_d = result;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= OP_PASS_A;
      s1_acc_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      out_q      <= '0;
      zero_q     <= 1'b0;
      ones_q     <= 1'b0;
      parity_q   <= 1'b0;
      acc_q      <= ACC_INIT;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s1_acc_q   <= s1_acc_d;
      s2_valid_q <= s2_valid_d;
      out_q      <= out_d;
      zero_q     <= zero_d;
      ones_q     <= ones_d;
      parity_q   <= parity_d;
      acc_q      <= acc_d;
    end
  end

  // Output drive
  always_comb begin
    OUT       = out_q;
    ZERO      = zero_q;
    ONES      = ones_q;
    PARITY    = parity_q;
    OUT_VALID = s2_valid_q;
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe (WIDTH=4).
module tb_logic_unit_pipe;

  logic       CLK;
  logic       RST_N;
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] OP;
  logic       ACC;
  logic       ACC_CLR;
  logic       IN_VALID;
  logic       IN_READY;
  logic [3:0] OUT;
  logic       ZERO;
  logic       ONES;
  logic       PARITY;
  logic       OUT_VALID;
  logic       OUT_READY;

  int n_checks;
  int n_fail;

  logic [3:0] exp_out [8];
  logic [2:0] exp_flg [8];

  logic_unit_pipe #(.WIDTH(4), .ACC_INIT(4'b0000)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .A         (A),
    .B         (B),
    .OP        (OP),
    .ACC       (ACC),
    .ACC_CLR   (ACC_CLR),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .OUT       (OUT),
    .ZERO      (ZERO),
    .ONES      (ONES),
    .PARITY    (PARITY),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; A = '0; B = '0; OP = '0; ACC = 0; ACC_CLR = 0;
    IN_VALID = 0; OUT_READY = 1;
    #12;
    n_checks++;
    if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", OUT_VALID); end
    n_checks++;
    if ({OUT, ZERO, ONES, PARITY} !== 7'b0) begin
      n_fail++; $display("FAIL reset_out_flags got=%b exp=0000000", {OUT, ZERO, ONES, PARITY});
    end
    RST_N = 1'b1;
    cyc();
    n_checks++;
    if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", IN_READY); end
  endtask

  task automatic test_all_ops();
    exp_out = '{4'b1011, 4'b0100, 4'b0001, 4'b1111, 4'b1110, 4'b1110, 4'b0000, 4'b0001};
    // {ZERO, ONES, PARITY}
    exp_flg = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b001, 3'b001, 3'b100, 3'b001};
    OUT_READY = 1; ACC = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        IN_VALID = 1; A = 4'b1011; B = 4'b0101; OP = 3'(i);
      end else begin
        IN_VALID = 0; A = 4'bxxxx; B = 4'bxxxx;
      end
      cyc();
      if (i >= 1 && i <= 8) begin
        n_checks++;
        if (OUT_VALID !== 1'b1 || OUT !== exp_out[i-1]) begin
          n_fail++; $display("FAIL op%0d_out got=%b/%b exp=1/%b", i-1, OUT_VALID, OUT, exp_out[i-1]);
        end
        n_checks++;
        if ({ZERO, ONES, PARITY} !== exp_flg[i-1]) begin
          n_fail++; $display("FAIL op%0d_flags got=%b exp=%b", i-1, {ZERO, ONES, PARITY}, exp_flg[i-1]);
        end
      end
      if (i == 9) begin
        n_checks++;
        if (OUT_VALID !== 1'b0 || OUT !== 4'b0001) begin
          n_fail++; $display("FAIL ops_drain got=%b/%b exp=0/0001", OUT_VALID, OUT);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    OUT_READY = 1; ACC = 0; IN_VALID = 1;
    A = 4'b1111; B = 4'b0000; OP = 3'd4;
    cyc();
    A = 4'b0101; B = 4'b1011; OP = 3'd2;
    cyc();
    IN_VALID = 0;
    n_checks++;
    if ({OUT_VALID, OUT, ZERO, ONES, PARITY} !== {1'b1, 4'b1111, 3'b010}) begin
      n_fail++; $display("FAIL b2b_first got=%b exp=11111010", {OUT_VALID, OUT, ZERO, ONES, PARITY});
    end
    cyc();
    n_checks++;
    if ({OUT_VALID, OUT, ZERO, ONES, PARITY} !== {1'b1, 4'b0001, 3'b001}) begin
      n_fail++; $display("FAIL b2b_second got=%b exp=10001001", {OUT_VALID, OUT, ZERO, ONES, PARITY});
    end
    cyc();
  endtask

  task automatic test_backpressure();
    ACC = 0; B = 4'b1111; OUT_READY = 0;
    IN_VALID = 1; A = 4'b0001; OP = 3'd0;
    n_checks++;
    if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL bp_ready0 got=%b exp=1", IN_READY); end
    cyc();
    A = 4'b0010; OP = 3'd0;
    n_checks++;
    if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL bp_ready1 got=%b exp=1", IN_READY); end
    cyc();
    A = 4'b0011; OP = 3'd1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1 || OUT !== 4'b0001) begin
        n_fail++; $display("FAIL bp_hold%0d got rdy=%b v=%b out=%b exp rdy=0 v=1 out=0001",
                           i, IN_READY, OUT_VALID, OUT);
      end
      if (i < 2) cyc();
    end
    OUT_READY = 1;
    #1;
    n_checks++;
    if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=1", IN_READY); end
    cyc();
    IN_VALID = 0;
    n_checks++;
    if (OUT_VALID !== 1'b1 || OUT !== 4'b0010) begin
      n_fail++; $display("FAIL bp_item1 got=%b/%b exp=1/0010", OUT_VALID, OUT);
    end
    cyc();
    n_checks++;
    if (OUT_VALID !== 1'b1 || OUT !== 4'b1100) begin
      n_fail++; $display("FAIL bp_item2 got=%b/%b exp=1/1100", OUT_VALID, OUT);
    end
    cyc();
    n_checks++;
    if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL bp_empty got=%b exp=0", OUT_VALID); end
  endtask

  task automatic test_accumulate();
    exp_out[0] = 4'b0011; exp_out[1] = 4'b0110; exp_out[2] = 4'b0000;
    OUT_READY = 1; IN_VALID = 0; ACC_CLR = 1;
    cyc();
    ACC_CLR = 0;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        IN_VALID = 1; ACC = 1; OP = 3'd4; B = 4'b1111;
        A = (i == 0) ? 4'b0011 : (i == 1) ? 4'b0101 : 4'b0110;
      end else begin
        IN_VALID = 0; ACC = 0;
      end
      cyc();
      if (i >= 1) begin
        n_checks++;
        if (OUT_VALID !== 1'b1 || OUT !== exp_out[i-1]) begin
          n_fail++; $display("FAIL acc%0d got=%b/%b exp=1/%b", i-1, OUT_VALID, OUT, exp_out[i-1]);
        end
      end
    end
    n_checks++;
    if (ZERO !== 1'b1) begin n_fail++; $display("FAIL acc_zero got=%b exp=1", ZERO); end
    cyc();
  endtask

  task automatic test_clr_collision();
    OUT_READY = 1; IN_VALID = 1; ACC = 0; A = 4'b0001; B = 4'b0000; OP = 3'd0;
    cyc();
    ACC = 1; A = 4'b1000; B = 4'b0000; OP = 3'd3;
    cyc();
    IN_VALID = 0; ACC = 0; ACC_CLR = 1;
    n_checks++;
    if (OUT !== 4'b0001) begin n_fail++; $display("FAIL clr_seed got=%b exp=0001", OUT); end
    cyc();
    ACC_CLR = 0;
    n_checks++;
    if (OUT_VALID !== 1'b1 || OUT !== 4'b1001) begin
      n_fail++; $display("FAIL clr_collide got=%b/%b exp=1/1001", OUT_VALID, OUT);
    end
    IN_VALID = 1; ACC = 1; A = 4'b0010; B = 4'b1111; OP = 3'd3;
    cyc();
    IN_VALID = 0; ACC = 0;
    cyc();
    n_checks++;
    if (OUT_VALID !== 1'b1 || OUT !== 4'b0010) begin
      n_fail++; $display("FAIL clr_after got=%b/%b exp=1/0010", OUT_VALID, OUT);
    end
    cyc();
  endtask

  task automatic test_reset_midstream();
    OUT_READY = 0; IN_VALID = 1; ACC = 0; B = 4'b0000; OP = 3'd0; A = 4'b1001;
    cyc();
    A = 4'b1010;
    cyc();
    n_checks++;
    if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1 || OUT !== 4'b1001) begin
      n_fail++; $display("FAIL mid_full got rdy=%b v=%b out=%b exp rdy=0 v=1 out=1001",
                         IN_READY, OUT_VALID, OUT);
    end
    IN_VALID = 0;
    #3;
    RST_N = 0;
    #1;
    n_checks++;
    if (OUT_VALID !== 1'b0 || OUT !== 4'b0000 || {ZERO, ONES, PARITY} !== 3'b000) begin
      n_fail++; $display("FAIL mid_async got v=%b out=%b flags=%b exp v=0 out=0000 flags=000",
                         OUT_VALID, OUT, {ZERO, ONES, PARITY});
    end
    #2;
    RST_N = 1;
    OUT_READY = 1;
    cyc();
    n_checks++;
    if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL mid_no_stale got=%b exp=0", OUT_VALID); end
    // Accumulator must be back at ACC_INIT, so OR with it returns A unchanged
    IN_VALID = 1; ACC = 1; OP = 3'd3; A = 4'b0110; B = 4'b1111;
    cyc();
    IN_VALID = 0; ACC = 0;
    n_checks++;
    if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL mid_lat got=%b exp=0", OUT_VALID); end
    cyc();
    n_checks++;
    if (OUT_VALID !== 1'b1 || OUT !== 4'b0110) begin
      n_fail++; $display("FAIL mid_first got=%b/%b exp=1/0110", OUT_VALID, OUT);
    end
    cyc();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_all_ops();
    test_back_to_back();
    test_backpressure();
    test_accumulate();
    test_clr_collision();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout sim_time=%0t limit=20000", $time);
    $fatal(1, "timeout");
  end

endmodule
